// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that issues one byte per UART frame to a downstream
// transmitter using a wr/ready handshake. Producers push freely and watch full.
module uart_tx_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [7:0]            push_data,
   input  logic                  flush,
   input  logic                  clear_ovf,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic                  idle,
   output logic                  tx_wr,
   output logic [7:0]            tx_din,
   input  logic                  tx_ready
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PW    = DEPTH_LOG2;
   localparam int unsigned LW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;

   logic [7:0]      mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr_d;
   logic [PW-1:0]   rd_ptr_d;
   logic [LW-1:0]   level_d;
   logic            overflow_d;

   logic            wr_en_c;
   logic            ovf_set_c;
   logic            pop_c;
   logic            tx_wr_d;
   logic [7:0]      tx_din_d;

   // Push qualification: full is the registered pre-edge value, so a push
   // into a full buffer is dropped even if a pop happens in the same cycle.
   always_comb begin
      wr_en_c   = push & ~full & ~flush;
      ovf_set_c = push &  full & ~flush;
   end

   // Storage array; write-only port, no reset needed on data.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Issue FSM next-state and handshake outputs.
   always_comb begin
      state_d  = state_q;
      pop_c    = 1'b0;
      tx_wr_d  = 1'b0;
      tx_din_d = tx_din;
      case (state_q)
         IDLE: begin
            if (!empty && tx_ready && !flush) begin
               pop_c    = 1'b1;
               tx_wr_d  = 1'b1;
               tx_din_d = mem[rd_ptr];
               state_d  = SEND;
            end
         end
         SEND: begin
            state_d = HOLD;
         end
         HOLD: begin
            if (tx_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pointer, occupancy and sticky overflow next values.
   always_comb begin
      wr_ptr_d   = wr_ptr;
      rd_ptr_d   = rd_ptr;
      level_d    = level;
      overflow_d = overflow;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_en_c) begin
            wr_ptr_d = wr_ptr + PW'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr + PW'(1);
         end
         level_d = level + LW'(wr_en_c) - LW'(pop_c);
      end
      if (ovf_set_c) begin
         overflow_d = 1'b1;
      end else if (clear_ovf) begin
         overflow_d = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Buffer bookkeeping registers; full/empty registered from next level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_d;
         rd_ptr   <= rd_ptr_d;
         level    <= level_d;
         full     <= (level_d == LW'(DEPTH));
         empty    <= (level_d == '0);
         overflow <= overflow_d;
      end
   end

   // Transmitter-facing strobe and data registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_wr  <= 1'b0;
         tx_din <= 8'h00;
      end else begin
         tx_wr  <= tx_wr_d;
         tx_din <= tx_din_d;
      end
   end

   // Everything handed off: nothing queued, no handshake open, transmitter free.
   assign idle = empty & (state_q == IDLE) & tx_ready;

endmodule
